acc_4_ctrl: RTL

- Sequencing and accumulator stage wrapped around the 4-bit ripple add/sub unit.
- Accepts one command per handshake: operand plus opcode.
- Drives the add/sub unit's A, B and M inputs, then captures its S, C and V outputs into a 4-bit accumulator and a flag register.
- Presents the result downstream with a valid/ready handshake.

---
 rtl/acc_4_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/acc_4_ctrl.sv
// -----------------------------------------------------------------------------
// acc_4_ctrl
//   Sequencing and accumulator stage for the external 4-bit ripple add/sub
//   unit. It accepts one command (opcode + operand) per handshake, presents
//   the accumulator and the operand to the add/sub unit for one EXEC cycle,
//   captures the unit's sum/carry/overflow into the accumulator and flag
//   registers, and then holds the result until downstream accepts it.
//
// Parameters
//   SAT_EN    1 = a signed overflow on ADD/SUB saturates the accumulator
//   ACC_INIT  accumulator value after reset
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   command handshake (op, operand)
//   op                    00 LOAD, 01 ADD, 10 SUB, 11 CMP
//   operand               4-bit command operand
//   add_A/add_B/add_M     drive the add/sub unit (M=1 subtracts)
//   add_S/add_C/add_V     sum, carry-out and signed overflow from the unit
//   out_valid / out_ready result handshake
//   acc                   accumulator
//   flag_c/v/z/n          carry, overflow, zero, negative flags
//   sticky_v, sticky_clr  sticky overflow flag and its clear
// -----------------------------------------------------------------------------
module acc_4_ctrl #(
    parameter bit         SAT_EN   = 1'b0,
    parameter logic [3:0] ACC_INIT = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] op,
    input  logic [3:0] operand,
    output logic [3:0] add_A,
    output logic [3:0] add_B,
    output logic       add_M,
    input  logic [3:0] add_S,
    input  logic       add_C,
    input  logic       add_V,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] acc,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_z,
    output logic       flag_n,
    output logic       sticky_v,
    input  logic       sticky_clr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    logic [1:0] state;
    logic [1:0] op_p0;
    logic [3:0] operand_p0;
    logic [3:0] arith_res;
    logic       exec;
    logic       sticky_set;

    // Saturation clamps toward the sign of the pre-op accumulator: an
    // overflow can only happen when the result sign flips away from it.
    function automatic logic [3:0] sat_result(input logic [3:0] sum,
                                              input logic       ovf,
                                              input logic       pre_msb);
        if (SAT_EN && ovf)
            return pre_msb ? 4'b1000 : 4'b0111;
        else
            return sum;
    endfunction

    assign exec       = (state == EXEC);
    assign arith_res  = sat_result(add_S, add_V, acc[3]);
    assign sticky_set = exec && (op_p0 != OP_LOAD) && add_V;

    // in_ready is gated by rst_n so it reads 0 throughout reset.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == HOLD);

    // Outside EXEC the unit sees acc + 0 in add mode; its outputs are unused.
    assign add_A = acc;
    assign add_B = exec ? operand_p0 : 4'b0000;
    assign add_M = exec && ((op_p0 == OP_SUB) || (op_p0 == OP_CMP));

    // Stage p0: command capture in IDLE, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_p0      <= 2'b00;
            operand_p0 <= 4'b0000;
            acc        <= ACC_INIT;
            flag_c     <= 1'b0;
            flag_v     <= 1'b0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_p0      <= op;
                        operand_p0 <= operand;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    state <= HOLD;
                    case (op_p0)
                        OP_LOAD: begin
                            acc    <= operand_p0;
                            flag_c <= 1'b0;
                            flag_v <= 1'b0;
                            flag_z <= (operand_p0 == 4'b0000);
                            flag_n <= operand_p0[3];
                        end
                        OP_CMP: begin
                            // Flags as for SUB, accumulator untouched.
                            flag_c <= add_C;
                            flag_v <= add_V;
                            flag_z <= (add_S == 4'b0000);
                            flag_n <= add_S[3];
                        end
                        default: begin
                            acc    <= arith_res;
                            flag_c <= add_C;
                            flag_v <= add_V;
                            flag_z <= (arith_res == 4'b0000);
                            flag_n <= arith_res[3];
                        end
                    endcase
                end
                HOLD: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_v <= 1'b0;
        else if (sticky_set)
            sticky_v <= 1'b1;
        else if (sticky_clr)
            sticky_v <= 1'b0;
    end

endmodule
